csr_unit: RTL and testbench

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_unit_pkg.sv | 36 +++
 rtl/csr_unit_if.sv | 43 ++++
 rtl/csr_counter.sv | 45 ++++
 rtl/csr_unit.sv | 162 ++++++++++++++++
 tb/tb_csr_unit.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_unit_pkg.sv
// ============================================================================
// Module : csr_unit_pkg
// Brief  : CSR addresses, mstatus/mie/mip bit positions, mtvec mode encodings
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package csr_unit_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  localparam int unsigned MIE_MTIE = 7;
  localparam int unsigned MIE_MEIE = 11;
  localparam int unsigned MIP_MTIP = 7;
  localparam int unsigned MIP_MEIP = 11;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

endpackage

`default_nettype wire

// File: rtl/csr_unit_if.sv
// ============================================================================
// Module : csr_unit_if
// Brief  : Core-to-CSR bus: read/write port, trap/return events, irq lines
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface csr_unit_if #(
  parameter int XLEN = 64
) ();
  logic            csr_re;
  logic [11:0]     csr_num;
  logic [XLEN-1:0] csr_rvalue;
  logic            csr_we;
  logic [XLEN-1:0] csr_wmask;
  logic [XLEN-1:0] csr_wvalue;
  logic            ex;
  logic            ex_intr;
  logic [XLEN-2:0] ecode;
  logic [XLEN-1:0] epc;
  logic            ex_ret;
  logic [XLEN-1:0] ret_pc;
  logic [XLEN-1:0] ex_entry;
  logic            irq_timer;
  logic            irq_ext;
  logic            irq_req;
  logic            instret;

  modport master (
    output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
           ex, ex_intr, ecode, epc, ex_ret, irq_timer, irq_ext, instret,
    input  csr_rvalue, ret_pc, ex_entry, irq_req
  );

  modport slave (
    input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
           ex, ex_intr, ecode, epc, ex_ret, irq_timer, irq_ext, instret,
    output csr_rvalue, ret_pc, ex_entry, irq_req
  );
endinterface

`default_nettype wire

// File: rtl/csr_counter.sv
// ============================================================================
// Module : csr_counter
// Brief  : Wrapping counter with increment enable; a masked write beats the increment
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module csr_counter #(
  parameter int XLEN = 64
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            inc_en,
  input  wire logic            we,
  input  wire logic [XLEN-1:0] wmask,
  input  wire logic [XLEN-1:0] wvalue,
  output logic      [XLEN-1:0] count
);

  logic [XLEN-1:0] count_q;
  logic [XLEN-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (we) begin
      count_d = (wmask & wvalue) | (~wmask & count_q);
    end else if (inc_en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/csr_unit.sv
// ============================================================================
// Module : csr_unit
// Brief  : Machine-mode CSR file with trap entry/return and interrupt gating
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module csr_unit
  import csr_unit_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter bit HAS_COUNTERS = 1
) (
  input  wire logic clk,
  input  wire logic rst,
  csr_unit_if.slave bus
);

  localparam logic [XLEN-1:0] LOW2 = XLEN'(3);

  logic            mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic            mtie_q, mtie_d, meie_q, meie_d;
  logic [XLEN-3:0] tvec_base_q, tvec_base_d;
  logic            tvec_mode_q, tvec_mode_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mcycle, minstret;
  logic [XLEN-1:0] tvec_rd, tvec_new, mstatus_rd, mie_rd, mip_rd, rdata;
  logic [XLEN-1:0] base_pc, vec_off;

  always_comb begin
    tvec_rd = {tvec_base_q, 1'b0, tvec_mode_q};
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MIE]  = mst_mie_q;
    mstatus_rd[MSTATUS_MPIE] = mst_mpie_q;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mie_rd = '0;
    mie_rd[MIE_MTIE] = mtie_q;
    mie_rd[MIE_MEIE] = meie_q;
    mip_rd = '0;
    mip_rd[MIP_MTIP] = bus.irq_timer;
    mip_rd[MIP_MEIP] = bus.irq_ext;
    tvec_new = (bus.csr_wmask & bus.csr_wvalue) | (~bus.csr_wmask & tvec_rd);
  end

  // Lowest priority first: csr_we, then mret, then trap entry overrides.
  always_comb begin
    mst_mie_d   = mst_mie_q;
    mst_mpie_d  = mst_mpie_q;
    mtie_d      = mtie_q;
    meie_d      = meie_q;
    tvec_base_d = tvec_base_q;
    tvec_mode_d = tvec_mode_q;
    mscratch_d  = mscratch_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;
    if (bus.csr_we) begin
      case (bus.csr_num)
        CSR_MSTATUS: begin
          if (bus.csr_wmask[MSTATUS_MIE])  mst_mie_d  = bus.csr_wvalue[MSTATUS_MIE];
          if (bus.csr_wmask[MSTATUS_MPIE]) mst_mpie_d = bus.csr_wvalue[MSTATUS_MPIE];
        end
        CSR_MIE: begin
          if (bus.csr_wmask[MIE_MTIE]) mtie_d = bus.csr_wvalue[MIE_MTIE];
          if (bus.csr_wmask[MIE_MEIE]) meie_d = bus.csr_wvalue[MIE_MEIE];
        end
        CSR_MTVEC: begin
          tvec_base_d = tvec_new[XLEN-1:2];
          if (tvec_new[1:0] == MTVEC_MODE_DIRECT || tvec_new[1:0] == MTVEC_MODE_VECTORED)
            tvec_mode_d = tvec_new[0];
        end
        CSR_MSCRATCH: mscratch_d = (bus.csr_wmask & bus.csr_wvalue) | (~bus.csr_wmask & mscratch_q);
        CSR_MEPC:     mepc_d = ((bus.csr_wmask & bus.csr_wvalue) | (~bus.csr_wmask & mepc_q)) & ~LOW2;
        CSR_MCAUSE:   mcause_d = (bus.csr_wmask & bus.csr_wvalue) | (~bus.csr_wmask & mcause_q);
        default: ;
      endcase
    end
    if (bus.ex) begin
      mepc_d     = bus.epc & ~LOW2;
      mcause_d   = {bus.ex_intr, bus.ecode};
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
    end else if (bus.ex_ret) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mst_mie_q   <= 1'b0;
      mst_mpie_q  <= 1'b0;
      mtie_q      <= 1'b0;
      meie_q      <= 1'b0;
      tvec_base_q <= '0;
      tvec_mode_q <= 1'b0;
      mscratch_q  <= '0;
      mepc_q      <= '0;
      mcause_q    <= '0;
    end else begin
      mst_mie_q   <= mst_mie_d;
      mst_mpie_q  <= mst_mpie_d;
      mtie_q      <= mtie_d;
      meie_q      <= meie_d;
      tvec_base_q <= tvec_base_d;
      tvec_mode_q <= tvec_mode_d;
      mscratch_q  <= mscratch_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
    end
  end

  generate
    if (HAS_COUNTERS) begin : g_counters
      csr_counter #(.XLEN(XLEN)) u_mcycle (
        .clk(clk), .rst(rst), .inc_en(1'b1),
        .we(bus.csr_we && bus.csr_num == CSR_MCYCLE),
        .wmask(bus.csr_wmask), .wvalue(bus.csr_wvalue), .count(mcycle)
      );
      csr_counter #(.XLEN(XLEN)) u_minstret (
        .clk(clk), .rst(rst), .inc_en(bus.instret),
        .we(bus.csr_we && bus.csr_num == CSR_MINSTRET),
        .wmask(bus.csr_wmask), .wvalue(bus.csr_wvalue), .count(minstret)
      );
    end else begin : g_no_counters
      assign mcycle   = '0;
      assign minstret = '0;
    end
  endgenerate

  always_comb begin
    rdata = '0;
    if (bus.csr_re) begin
      case (bus.csr_num)
        CSR_MSTATUS:  rdata = mstatus_rd;
        CSR_MIE:      rdata = mie_rd;
        CSR_MTVEC:    rdata = tvec_rd;
        CSR_MSCRATCH: rdata = mscratch_q;
        CSR_MEPC:     rdata = mepc_q;
        CSR_MCAUSE:   rdata = mcause_q;
        CSR_MIP:      rdata = mip_rd;
        CSR_MCYCLE:   rdata = mcycle;
        CSR_MINSTRET: rdata = minstret;
        default:      rdata = '0;
      endcase
    end
  end

  // Vectored offset is code<<2; the shift drops the top code bits so the sum wraps at XLEN.
  assign base_pc = {tvec_base_q, 2'b00};
  assign vec_off = {mcause_q[XLEN-3:0], 2'b00};

  assign bus.csr_rvalue = rdata;
  assign bus.ret_pc     = mepc_q;
  assign bus.ex_entry   = (tvec_mode_q && mcause_q[XLEN-1]) ? base_pc + vec_off : base_pc;
  assign bus.irq_req    = mst_mie_q & ((mtie_q & bus.irq_timer) | (meie_q & bus.irq_ext));

endmodule

`default_nettype wire

// File: tb/tb_csr_unit.sv
// ============================================================================
// Module : tb_csr_unit
// Brief  : Directed stimulus with queued expectations, checked by a monitor
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_csr_unit;
  import csr_unit_pkg::*;

  localparam int XLEN = 64;
  localparam logic [XLEN-1:0] ONES = '1;

  logic clk = 1'b0;
  logic rst;
  logic probe;
  always #5 clk = ~clk;

  csr_unit_if #(.XLEN(XLEN)) bus ();

  csr_unit #(.XLEN(XLEN), .HAS_COUNTERS(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string           name;
    logic [XLEN-1:0] val;
  } rd_exp_t;

  typedef struct {
    string           name;
    logic            irq;
    logic [XLEN-1:0] entry;
    logic [XLEN-1:0] ret;
  } side_exp_t;

  rd_exp_t   rd_q[$];
  side_exp_t side_q[$];
  rd_exp_t   rd_e;
  side_exp_t side_e;
  int n_cmp = 0;
  int n_bad = 0;

  always @(negedge clk) begin
    if (bus.csr_re) begin
      n_cmp++;
      if (rd_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_read: addr=%h data=%h with no expectation", bus.csr_num, bus.csr_rvalue);
      end else begin
        rd_e = rd_q.pop_front();
        if (bus.csr_rvalue !== rd_e.val) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", rd_e.name, bus.csr_rvalue, rd_e.val);
        end
      end
    end
    if (probe) begin
      if (side_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_probe: no expectation queued");
      end else begin
        side_e = side_q.pop_front();
        n_cmp += 4;
        if (bus.irq_req !== side_e.irq) begin
          n_bad++;
          $display("FAIL %s.irq_req: got %b expected %b", side_e.name, bus.irq_req, side_e.irq);
        end
        if (bus.ex_entry !== side_e.entry) begin
          n_bad++;
          $display("FAIL %s.ex_entry: got %h expected %h", side_e.name, bus.ex_entry, side_e.entry);
        end
        if (bus.ret_pc !== side_e.ret) begin
          n_bad++;
          $display("FAIL %s.ret_pc: got %h expected %h", side_e.name, bus.ret_pc, side_e.ret);
        end
        if (bus.csr_rvalue !== '0) begin
          n_bad++;
          $display("FAIL %s.rvalue_idle: got %h expected 0", side_e.name, bus.csr_rvalue);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    bus.csr_re = 1'b0; bus.csr_we = 1'b0; bus.ex = 1'b0; bus.ex_ret = 1'b0; bus.instret = 1'b0;
  endtask

  task automatic set_wr(input logic [11:0] a, input logic [XLEN-1:0] m, input logic [XLEN-1:0] v);
    bus.csr_we = 1'b1; bus.csr_num = a; bus.csr_wmask = m; bus.csr_wvalue = v;
  endtask

  task automatic set_trap(input logic intr, input logic [XLEN-1:0] code, input logic [XLEN-1:0] pc);
    bus.ex = 1'b1; bus.ex_intr = intr; bus.ecode = code[XLEN-2:0]; bus.epc = pc;
  endtask

  task automatic go();
    step();
    clear();
  endtask

  task automatic wr(input logic [11:0] a, input logic [XLEN-1:0] m, input logic [XLEN-1:0] v);
    set_wr(a, m, v);
    go();
  endtask

  task automatic rd(input logic [11:0] a, input logic [XLEN-1:0] v, input string n);
    bus.csr_re = 1'b1; bus.csr_num = a;
    rd_q.push_back('{name: n, val: v});
    step();
    bus.csr_re = 1'b0;
  endtask

  task automatic chk(input logic irq, input logic [XLEN-1:0] entry, input logic [XLEN-1:0] ret,
                     input string n);
    probe = 1'b1;
    side_q.push_back('{name: n, irq: irq, entry: entry, ret: ret});
    step();
    probe = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; probe = 1'b0;
    clear();
    bus.csr_num = '0; bus.csr_wmask = '0; bus.csr_wvalue = '0;
    bus.ex_intr = 1'b0; bus.ecode = '0; bus.epc = '0;
    bus.irq_timer = 1'b0; bus.irq_ext = 1'b0;
    // reset must win over a concurrent trap and write
    set_wr(CSR_MSCRATCH, ONES, 64'h77);
    set_trap(1'b1, 64'd5, 64'h1234);
    repeat (3) step();
    rst = 1'b0;
    clear();

    rd(CSR_MCYCLE, 64'h0, "rst_mcycle");
    chk(1'b0, 64'h0, 64'h0, "rst_outputs");
    rd(CSR_MSTATUS,  64'h1800, "rst_mstatus");
    rd(CSR_MIE,      64'h0, "rst_mie");
    rd(CSR_MTVEC,    64'h0, "rst_mtvec");
    rd(CSR_MSCRATCH, 64'h0, "rst_mscratch");
    rd(CSR_MEPC,     64'h0, "rst_mepc");
    rd(CSR_MCAUSE,   64'h0, "rst_mcause");
    rd(CSR_MINSTRET, 64'h0, "rst_minstret");
    rd(12'h123,      64'h0, "unimpl_read");

    wr(CSR_MTVEC, ONES, 64'h8000_0001);
    rd(CSR_MTVEC, 64'h8000_0001, "mtvec_vectored");
    set_trap(1'b1, 64'd7, 64'h4000); go();
    chk(1'b0, 64'h8000_001C, 64'h4000, "vec_entry");
    rd(CSR_MCAUSE, 64'h8000_0000_0000_0007, "mcause_intr7");

    wr(CSR_MSTATUS, ONES, 64'h8);
    rd(CSR_MSTATUS, 64'h1808, "mstatus_mie1");
    wr(CSR_MIE, ONES, 64'h80);
    bus.irq_timer = 1'b1;
    chk(1'b1, 64'h8000_001C, 64'h4000, "irq_timer_req");
    set_trap(1'b1, 64'd7, 64'h5004); go();
    rd(CSR_MSTATUS, 64'h1880, "trap_mstatus");
    chk(1'b0, 64'h8000_001C, 64'h5004, "trap_irq_off");
    bus.ex_ret = 1'b1; go();
    rd(CSR_MSTATUS, 64'h1888, "mret_mstatus");
    chk(1'b1, 64'h8000_001C, 64'h5004, "mret_irq_on");
    bus.irq_timer = 1'b0;
    chk(1'b0, 64'h8000_001C, 64'h5004, "timer_drop");
    bus.irq_ext = 1'b1;
    chk(1'b0, 64'h8000_001C, 64'h5004, "ext_masked");
    wr(CSR_MIE, ONES, 64'hFFFF);
    rd(CSR_MIE, 64'h880, "mie_writable_bits");
    chk(1'b1, 64'h8000_001C, 64'h5004, "ext_req");
    bus.irq_ext = 1'b0;

    set_trap(1'b0, 64'd2, 64'h1003);
    set_wr(CSR_MEPC, ONES, 64'h2000);
    go();
    rd(CSR_MEPC, 64'h1000, "ex_beats_we_mepc");
    chk(1'b0, 64'h8000_0000, 64'h1000, "exc_entry_base");
    rd(CSR_MCAUSE, 64'h2, "mcause_exc2");
    wr(CSR_MEPC, ONES, 64'h2003);
    rd(CSR_MEPC, 64'h2000, "mepc_align");

    wr(CSR_MSCRATCH, ONES, 64'hABCD);
    wr(CSR_MSCRATCH, 64'hFF00, 64'h1234);
    rd(CSR_MSCRATCH, 64'h12CD, "masked_write");
    set_trap(1'b0, 64'd2, 64'h3000);
    set_wr(CSR_MSCRATCH, ONES, 64'h5555);
    go();
    rd(CSR_MSCRATCH, 64'h5555, "untouched_takes_we");
    rd(CSR_MEPC, 64'h3000, "trap_mepc");

    wr(CSR_MTVEC, 64'h3, 64'h2);
    rd(CSR_MTVEC, 64'h8000_0001, "mode2_ignored");
    wr(CSR_MIP, ONES, 64'hFFFF);
    bus.irq_timer = 1'b1;
    rd(CSR_MIP, 64'h80, "mip_timer");
    bus.irq_timer = 1'b0;
    rd(CSR_MIP, 64'h0, "mip_readonly");
    wr(CSR_MTVEC, 64'h3, 64'h0);
    rd(CSR_MTVEC, 64'h8000_0000, "mode0");

    wr(CSR_MSTATUS, ONES, 64'hFFFF_FFFF);
    rd(CSR_MSTATUS, 64'h1888, "mstatus_writable_bits");
    set_trap(1'b1, 64'd3, 64'h6000);
    bus.ex_ret = 1'b1;
    go();
    rd(CSR_MSTATUS, 64'h1880, "ex_beats_mret");
    chk(1'b0, 64'h8000_0000, 64'h6000, "direct_entry_intr");
    wr(CSR_MTVEC, 64'h3, 64'h1);
    chk(1'b0, 64'h8000_000C, 64'h6000, "vec_entry_code3");

    wr(CSR_MCYCLE, ONES, ONES);
    rd(CSR_MCYCLE, ONES, "mcycle_max");
    rd(CSR_MCYCLE, 64'h0, "mcycle_wrap");
    bus.instret = 1'b1;
    set_wr(CSR_MINSTRET, ONES, 64'd5);
    go();
    rd(CSR_MINSTRET, 64'd5, "we_beats_instret");
    bus.instret = 1'b1;
    rd(CSR_MINSTRET, 64'd5, "minstret_pre_update");
    bus.instret = 1'b0;
    rd(CSR_MINSTRET, 64'd6, "minstret_inc");

    rst = 1'b1;
    set_trap(1'b1, 64'd9, 64'h7000);
    set_wr(CSR_MSCRATCH, ONES, 64'h99);
    step();
    rst = 1'b0;
    clear();
    rd(CSR_MCYCLE, 64'h0, "rst2_mcycle");
    chk(1'b0, 64'h0, 64'h0, "rst2_outputs");
    rd(CSR_MSCRATCH, 64'h0, "rst2_mscratch");
    rd(CSR_MTVEC, 64'h0, "rst2_mtvec");
    rd(CSR_MSTATUS, 64'h1800, "rst2_mstatus");

    repeat (2) step();
    if (rd_q.size() != 0 || side_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d reads and %0d probes left unchecked, expected 0", rd_q.size(), side_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
